// File: rtl/ysyx_23060124_lsu_pkg.sv
// Shared types and constants for the ysyx_23060124 load/store stage.
// Holds the FSM state encoding, RV32 funct3 access codes and the
// bit layout of the packed writeback-control word.
package ysyx_23060124_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } lsu_state_t;

  // funct3 encodings; loads and stores share the size bits [1:0]
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Writeback-control word layout, MSB first: wen, rd_addr, csr_addr,
  // csr_wen, brch, jal, jalr, ebreak, mret, ecall, pc_next
  localparam int WB_INFO_W      = 56;
  localparam int WB_PC_NEXT_LSB = 0;
  localparam int WB_ECALL_BIT   = 32;
  localparam int WB_MRET_BIT    = 33;
  localparam int WB_EBREAK_BIT  = 34;
  localparam int WB_JALR_BIT    = 35;
  localparam int WB_JAL_BIT     = 36;
  localparam int WB_BRCH_BIT    = 37;
  localparam int WB_CSR_WEN_BIT = 38;
  localparam int WB_CSR_ADDR_LSB = 39;
  localparam int WB_RD_ADDR_LSB = 51;
  localparam int WB_WEN_BIT     = 55;

  // A faulting access must not write the register file; everything else
  // (including csr_wen) is carried through so the trap logic sees it.
  function automatic logic [WB_INFO_W-1:0] clear_wen(input logic [WB_INFO_W-1:0] wb);
    logic [WB_INFO_W-1:0] r;
    r = wb;
    r[WB_WEN_BIT] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/ysyx_23060124_lsu_align.sv
// Combinational byte-lane logic for the load/store stage.
// Extracts and extends load data, shifts store data onto lanes, builds
// byte strobes and flags misaligned half/word accesses.
module ysyx_23060124_lsu_align
  import ysyx_23060124_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  input  logic [1:0]  chk_addr_lo,
  input  logic [2:0]  chk_funct3,
  output logic [31:0] load_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [1:0]  size,
  output logic        misaligned
);

  logic [4:0]  lane_shift;
  logic [31:0] rshift;
  logic [3:0]  base_strb;

  assign lane_shift = {addr_lo, 3'b000};
  assign rshift     = rdata >> lane_shift;
  assign wdata      = store_data << lane_shift;

  // Load extract: low bits of the shifted word, sign or zero extended
  always_comb begin
    load_data = rshift;
    case (funct3)
      F3_B:    load_data = {{24{rshift[7]}}, rshift[7:0]};
      F3_H:    load_data = {{16{rshift[15]}}, rshift[15:0]};
      F3_BU:   load_data = {24'd0, rshift[7:0]};
      F3_HU:   load_data = {16'd0, rshift[15:0]};
      default: load_data = rshift;
    endcase
  end

  // Access size and strobes; reads drive no strobes
  always_comb begin
    size      = 2'd2;
    base_strb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin size = 2'd0; base_strb = 4'b0001; end
      2'b01: begin size = 2'd1; base_strb = 4'b0011; end
      default: begin size = 2'd2; base_strb = 4'b1111; end
    endcase
    wstrb = is_store ? (base_strb << addr_lo) : 4'b0000;
  end

  // Misalignment check on the not-yet-latched operands at accept time
  always_comb begin
    misaligned = 1'b0;
    case (chk_funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = chk_addr_lo[0];
      default: misaligned = (chk_addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/ysyx_23060124_lsu.sv
// Load/store stage: one memory access per instruction, results to writeback.
// Latency: non-memory 1 cycle, memory >= 3 cycles (accept, req, rsp).
// Backpressure: accepts only in IDLE; holds REQ on req_ready low, DONE on post_ready low.
module ysyx_23060124_lsu
  import ysyx_23060124_lsu_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_pre_valid,
  output logic                 o_pre_ready,
  input  logic [31:0]          i_res,
  input  logic [31:0]          i_store_data,
  input  logic                 i_mem_ren,
  input  logic                 i_mem_wen,
  input  logic [2:0]           i_funct3,
  input  logic [WB_INFO_W-1:0] i_wb_info,
  output logic                 o_post_valid,
  input  logic                 i_post_ready,
  output logic [31:0]          o_res,
  output logic [WB_INFO_W-1:0] o_wb_info,
  output logic                 o_fault,
  output logic                 o_mem_req_valid,
  input  logic                 i_mem_req_ready,
  output logic [31:0]          o_mem_addr,
  output logic                 o_mem_wen,
  output logic [31:0]          o_mem_wdata,
  output logic [3:0]           o_mem_wstrb,
  output logic [1:0]           o_mem_size,
  input  logic                 i_mem_rsp_valid,
  input  logic [31:0]          i_mem_rdata,
  input  logic                 i_mem_rsp_err
);

  lsu_state_t  state, next_state;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic [2:0]  f3_q;
  logic        store_q;
  logic        mem_op;
  logic        misaligned;
  logic [31:0] load_data;

  // Store wins when both request bits are set, so ren only matters alone
  assign mem_op = i_mem_ren | i_mem_wen;

  ysyx_23060124_lsu_align u_align (
    .addr_lo     (addr_q[1:0]),
    .funct3      (f3_q),
    .is_store    (store_q),
    .store_data  (sdata_q),
    .rdata       (i_mem_rdata),
    .chk_addr_lo (i_res[1:0]),
    .chk_funct3  (i_funct3),
    .load_data   (load_data),
    .wdata       (o_mem_wdata),
    .wstrb       (o_mem_wstrb),
    .size        (o_mem_size),
    .misaligned  (misaligned)
  );

  // All handshake outputs decode straight from the state register
  assign o_pre_ready     = (state == IDLE);
  assign o_post_valid    = (state == DONE);
  assign o_mem_req_valid = (state == REQ);
  assign o_mem_addr      = addr_q;
  assign o_mem_wen       = store_q;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_pre_valid) begin
          if (!mem_op || misaligned) next_state = DONE;
          else                       next_state = REQ;
        end
      end
      REQ:      if (i_mem_req_ready) next_state = WAIT_RSP;
      WAIT_RSP: if (i_mem_rsp_valid) next_state = DONE;
      DONE:     if (i_post_ready)    next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Operand latch at accept and result capture at response
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q    <= 32'd0;
      sdata_q   <= 32'd0;
      f3_q      <= 3'd0;
      store_q   <= 1'b0;
      o_res     <= 32'd0;
      o_wb_info <= '0;
      o_fault   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_pre_valid) begin
            addr_q  <= i_res;
            sdata_q <= i_store_data;
            f3_q    <= i_funct3;
            store_q <= i_mem_wen;
            // Passthrough and misaligned both report the address/result
            o_res   <= i_res;
            o_fault <= mem_op && misaligned;
            o_wb_info <= (mem_op && misaligned) ? clear_wen(i_wb_info) : i_wb_info;
          end
        end
        WAIT_RSP: begin
          if (i_mem_rsp_valid) begin
            o_res   <= store_q ? addr_q : load_data;
            o_fault <= i_mem_rsp_err;
            if (i_mem_rsp_err) o_wb_info <= clear_wen(o_wb_info);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_lsu.sv
module tb_ysyx_23060124_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_pre_valid;
  logic        o_pre_ready;
  logic [31:0] i_res;
  logic [31:0] i_store_data;
  logic        i_mem_ren;
  logic        i_mem_wen;
  logic [2:0]  i_funct3;
  logic [55:0] i_wb_info;
  logic        o_post_valid;
  logic        i_post_ready;
  logic [31:0] o_res;
  logic [55:0] o_wb_info;
  logic        o_fault;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic [1:0]  o_mem_size;
  logic        i_mem_rsp_valid;
  logic [31:0] i_mem_rdata;
  logic        i_mem_rsp_err;

  always #5 clock = ~clock;

  ysyx_23060124_lsu dut (
    .clock(clock), .reset(reset),
    .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready),
    .i_res(i_res), .i_store_data(i_store_data),
    .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen), .i_funct3(i_funct3),
    .i_wb_info(i_wb_info),
    .o_post_valid(o_post_valid), .i_post_ready(i_post_ready),
    .o_res(o_res), .o_wb_info(o_wb_info), .o_fault(o_fault),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb), .o_mem_size(o_mem_size),
    .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rdata(i_mem_rdata),
    .i_mem_rsp_err(i_mem_rsp_err)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [55:0] wb;
    logic        fault;
  } res_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  size;
  } req_t;

  res_t res_q[$];
  req_t req_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [55:0] WB1 = 56'hA5_5A5A_DEAD_BEEF;
  localparam logic [55:0] WB1_NOWEN = 56'h25_5A5A_DEAD_BEEF;
  localparam logic [55:0] WB2 = 56'hFF_0000_0000_1111;
  localparam logic [55:0] WB2_NOWEN = 56'h7F_0000_0000_1111;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare bus requests (every cycle they are offered) and results
  always @(negedge clock) begin
    if (!reset) begin
      if (o_mem_req_valid) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", {63'd0, o_mem_req_valid}, 64'd0);
        end else begin
          chk("req_addr",  {32'd0, o_mem_addr},  {32'd0, req_q[0].addr});
          chk("req_wen",   {63'd0, o_mem_wen},   {63'd0, req_q[0].wen});
          chk("req_wdata", {32'd0, o_mem_wdata}, {32'd0, req_q[0].wdata});
          chk("req_wstrb", {60'd0, o_mem_wstrb}, {60'd0, req_q[0].wstrb});
          chk("req_size",  {62'd0, o_mem_size},  {62'd0, req_q[0].size});
          if (i_mem_req_ready) void'(req_q.pop_front());
        end
      end
      if (o_post_valid && i_post_ready) begin
        if (res_q.size() == 0) begin
          chk("unexpected_result", {63'd0, o_post_valid}, 64'd0);
        end else begin
          chk("res",     {32'd0, o_res},     {32'd0, res_q[0].res});
          chk("wb_info", {8'd0, o_wb_info},  {8'd0, res_q[0].wb});
          chk("fault",   {63'd0, o_fault},   {63'd0, res_q[0].fault});
          void'(res_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50 && !o_pre_ready; k++) tick();
    chk("idle_timeout", {63'd0, o_pre_ready}, 64'd1);
  endtask

  // Issue one instruction, play the bus side, push expectations
  task automatic issue(
    input logic [31:0] res, input logic [31:0] sdata, input logic [2:0] f3,
    input logic ren, input logic wen, input logic [55:0] wb,
    input int stall, input logic [31:0] rdata, input logic err, input int pstall,
    input logic req_exp, input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
    input logic [1:0] e_size, input logic [31:0] e_res, input logic e_fault,
    input logic [55:0] e_wb);
    wait_idle();
    res_q.push_back('{res: e_res, wb: e_wb, fault: e_fault});
    if (req_exp) req_q.push_back('{addr: res, wen: wen, wdata: e_wdata, wstrb: e_wstrb, size: e_size});
    i_pre_valid = 1'b1; i_res = res; i_store_data = sdata; i_funct3 = f3;
    i_mem_ren = ren; i_mem_wen = wen; i_wb_info = wb;
    i_post_ready = (pstall == 0);
    tick();
    i_pre_valid = 1'b0; i_mem_ren = 1'b0; i_mem_wen = 1'b0;
    if (!req_exp) begin
      chk("lat_direct", {63'd0, o_post_valid}, 64'd1);
    end else begin
      for (int s = 0; s < stall; s++) begin
        // Stray responses outside WAIT_RSP must be ignored
        i_mem_rsp_valid = 1'b1; i_mem_rdata = 32'h5555_5555; i_mem_rsp_err = 1'b0;
        tick();
      end
      i_mem_rsp_valid = 1'b0;
      i_mem_req_ready = 1'b1;
      tick();
      i_mem_req_ready = 1'b0;
      i_mem_rsp_valid = 1'b1; i_mem_rdata = rdata; i_mem_rsp_err = err;
      tick();
      i_mem_rsp_valid = 1'b0; i_mem_rsp_err = 1'b0;
      if (stall == 0) chk("lat_mem", {63'd0, o_post_valid}, 64'd1);
    end
    for (int p = 0; p < pstall; p++) tick();
    i_post_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; i_pre_valid = 1'b0; i_res = '0; i_store_data = '0;
    i_mem_ren = 1'b0; i_mem_wen = 1'b0; i_funct3 = '0; i_wb_info = '0;
    i_post_ready = 1'b1; i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0;
    i_mem_rdata = '0; i_mem_rsp_err = 1'b0;
    tick(); tick();
    chk("rst_pre_ready", {63'd0, o_pre_ready}, 64'd1);
    chk("rst_ctrl", {61'd0, o_post_valid, o_mem_req_valid, o_fault}, 64'd0);
    chk("rst_res", {32'd0, o_res}, 64'd0);
    chk("rst_wb", {8'd0, o_wb_info}, 64'd0);
    chk("rst_mem", {o_mem_addr, o_mem_wdata[24:0], o_mem_wen, o_mem_wstrb, o_mem_size}, 64'd0);
    chk("rst_wdata_hi", {57'd0, o_mem_wdata[31:25]}, 64'd0);
    reset = 1'b0;

    // ALU passthrough
    issue(32'h1234, 0, 3'b000, 0, 0, WB1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234, 0, WB1);
    // LB / LBU at byte 3
    issue(32'h8000_0003, 0, 3'b000, 1, 0, WB1, 0, 32'h80FF_0000, 0, 0,
          1, 32'h0, 4'b0000, 2'd0, 32'hFFFF_FF80, 0, WB1);
    issue(32'h8000_0003, 0, 3'b100, 1, 0, WB2, 0, 32'h80FF_0000, 0, 0,
          1, 32'h0, 4'b0000, 2'd0, 32'h0000_0080, 0, WB2);
    // SH at halfword 2
    issue(32'h8000_0002, 32'h0000_ABCD, 3'b001, 0, 1, WB1, 0, 0, 0, 0,
          1, 32'hABCD_0000, 4'b1100, 2'd1, 32'h8000_0002, 0, WB1);
    // Misaligned LW: no bus access, fault, wen cleared
    issue(32'h8000_0001, 0, 3'b010, 1, 0, WB2, 0, 0, 0, 0,
          0, 0, 0, 0, 32'h8000_0001, 1, WB2_NOWEN);
    // LH with 5 cycles of req stall and a bus error
    issue(32'h8000_0002, 0, 3'b001, 1, 0, WB1, 5, 32'h1234_5678, 1, 0,
          1, 32'h0, 4'b0000, 2'd1, 32'h0000_1234, 1, WB1_NOWEN);
    // LH sign extend, LHU zero extend
    issue(32'h8000_0002, 0, 3'b001, 1, 0, WB2, 0, 32'h8001_0000, 0, 0,
          1, 32'h0, 4'b0000, 2'd1, 32'hFFFF_8001, 0, WB2);
    issue(32'h8000_0000, 0, 3'b101, 1, 0, WB1, 0, 32'h0000_9ABC, 0, 0,
          1, 32'h0, 4'b0000, 2'd1, 32'h0000_9ABC, 0, WB1);
    // SB lane 1, SW, LW
    issue(32'h8000_0001, 32'h1234_5678, 3'b000, 0, 1, WB1, 0, 0, 0, 0,
          1, 32'h3456_7800, 4'b0010, 2'd0, 32'h8000_0001, 0, WB1);
    issue(32'h8000_0004, 32'hDEAD_BEEF, 3'b010, 0, 1, WB2, 0, 0, 0, 0,
          1, 32'hDEAD_BEEF, 4'b1111, 2'd2, 32'h8000_0004, 0, WB2);
    issue(32'h8000_0008, 0, 3'b010, 1, 0, WB1, 0, 32'hCAFE_F00D, 0, 2,
          1, 32'h0, 4'b0000, 2'd2, 32'hCAFE_F00D, 0, WB1);
    // ren+wen both set: store wins
    issue(32'h8000_0020, 32'h0102_0304, 3'b010, 1, 1, WB1, 0, 32'hFFFF_FFFF, 0, 0,
          1, 32'h0102_0304, 4'b1111, 2'd2, 32'h8000_0020, 0, WB1);
    // Misaligned SH; ALU op with writeback backpressure
    issue(32'h8000_0003, 32'h0000_1111, 3'b001, 0, 1, WB2, 0, 0, 0, 0,
          0, 0, 0, 0, 32'h8000_0003, 1, WB2_NOWEN);
    issue(32'h0000_0042, 0, 3'b000, 0, 0, WB2, 0, 0, 0, 3, 0, 0, 0, 0, 32'h0000_0042, 0, WB2);

    // Reset while waiting for a response, then a late response
    wait_idle();
    req_q.push_back('{addr: 32'h8000_0010, wen: 1'b0, wdata: 32'h0, wstrb: 4'b0, size: 2'd2});
    i_pre_valid = 1'b1; i_res = 32'h8000_0010; i_funct3 = 3'b010; i_mem_ren = 1'b1; i_wb_info = WB1;
    tick();
    i_pre_valid = 1'b0; i_mem_ren = 1'b0;
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_pre_ready", {63'd0, o_pre_ready}, 64'd1);
    chk("rst_mid_res", {32'd0, o_res}, 64'd0);
    i_mem_rsp_valid = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
    tick();
    i_mem_rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("late_rsp_post_valid", {63'd0, o_post_valid}, 64'd0);
      chk("late_rsp_pre_ready", {63'd0, o_pre_ready}, 64'd1);
      tick();
    end

    tick();
    chk("res_q_drained", res_q.size(), 64'd0);
    chk("req_q_drained", req_q.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
